dice_roll_controller: RTL and testbench
=======================================

Name: dice_roll_controller

Overview:
- Sequencing controller for the dice display datapath. It accepts debounced die-select buttons and latches the die size.
- While a button is held, the BCD value spins once per clk cycle, using the hold time as entropy. After release it runs a slowing animation paced by the 32 Hz tick and settles on a result.
- It drives the two BCD digits and the blanking and status flags consumed by the seven-segment mux and decoder.

Parameters:
- ANIM_STEPS, 8, number of decrement steps in the settle animation (even, 2..16).

Ports:
- clk, input, 1, system clock (32768 Hz).
- rst, input, 1, synchronous reset, active-high; sampled on posedge clk.
- tick, input, 1, one-clk pulse at 32 Hz from the prescaler.
- btn, input, 7, debounced die selects, active-high: [0]=d4, [1]=d6, [2]=d8, [3]=d10, [4]=d12, [5]=d20, [6]=d100.
- digit10, output, 4, tens BCD digit.
- digit1, output, 4, units BCD digit.
- blank_tens, output, 1, combinational: 1 when digit10==0 and the latched die is not d100.
- rolling, output, 1, 1 in HOLD or SETTLE.
- result_valid, output, 1, one-clk pulse when a roll completes.

Behaviour:
- Single clock domain. All state updates on posedge clk. Reset is synchronous, active-high, and overrides everything.
- Reset values:
  - state=IDLE, digit10=0, digit1=1.
  - Latched die = d6.
  - step=0, wait_cnt=0, any_prev=0.
  - rolling=0, result_valid=0.
  - blank_tens=1.
- any = OR of btn. any_prev is a registered copy of any. Press edge = any & ~any_prev.
- IDLE:
  - Holds the last value.
  - On press edge: latch die = lowest-index set bit of btn (simultaneous presses resolve by lowest index). Load value = top of die: d4→04, d6→06, d8→08, d10→10, d12→12, d20→20, d100→00. Go to HOLD.
  - Buttons held through reset, or held without an edge, are ignored.
- HOLD:
  - Each cycle with any=1: decrement value once. Other buttons pressed meanwhile are ignored; the die stays latched.
  - First cycle with any=0: go to SETTLE with step=0 and wait_cnt=0. No decrement in that cycle.
- Decrement rule, in BCD:
  - d100: 00 wraps to 99, otherwise value-1. Range is 00..99.
  - Other dice: 01 wraps to N, otherwise value-1. Range is 01..N.
  - Units borrow: digit1 0→9 with digit10-1.
- SETTLE:
  - Ignores btn entirely; new presses are dropped and do not queue.
  - On each tick: if wait_cnt+1 == (step>>1)+1, decrement value, set step+1 and wait_cnt=0; otherwise wait_cnt+1.
  - Per-step tick intervals are 1,1,2,2,3,3,4,4 for ANIM_STEPS=8, totalling 20 ticks.
  - In the cycle the final step's decrement occurs, go to DONE.
- DONE:
  - Lasts exactly one cycle with result_valid=1, then goes to IDLE.
  - A press edge in that same cycle is ignored. any_prev still updates, so a button held across DONE does not restart a roll.
- rolling is registered: 1 exactly while state is HOLD or SETTLE.
- Value width: digit10 ≤ 9 and digit1 ≤ 9 always. A value above N is never produced.
- Reset mid-HOLD or mid-SETTLE returns to IDLE showing 01 with no result_valid pulse.
- tick during HOLD or IDLE has no effect.

Test Plan:
- Reset → digit10=0, digit1=1, rolling=0, result_valid=0, blank_tens=1; held stable for 100 cycles with no btn.
- btn=0000010 held 5 cycles from IDLE → HOLD loads 06, then 4 decrements → 02. After release, 8 steps → 01,06,05,04,03,02,01,06. Final 06; result_valid pulses once, exactly 1 cycle after the 20th tick following release.
- btn=1000000 held 3 cycles → 00→99→98. After settle → 90. blank_tens=0 throughout. A final value of 00 (hold 9 cycles: 00→92, settle→84; repeat with holds chosen to reach 00) also shows blank_tens=0.
- btn=0101000 pressed simultaneously → d10 latched (bit 3 wins), value loads 10. Pressing btn[0] during SETTLE → ignored; final result is within 01..10 and matches the model.
- Assert rst on the 3rd tick of SETTLE → next cycle value=01, state IDLE, rolling=0, no result_valid. With btn still held after rst drops → no roll until release and re-press.
- d4 hold 2 cycles: 04→03; settle 8 decrements mod 4 → 03. Check wrap 01→04 occurs and digit10 stays 0 with blank_tens=1.

Source files
------------

// File: rtl/dice_roll_controller.sv
// Dice roll sequencer: latches the selected die, spins the BCD value while a
// button is held, then runs a tick-paced slowing animation and settles.
module dice_roll_controller #(
  parameter int ANIM_STEPS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [6:0] btn,
  output logic [3:0] digit10,
  output logic [3:0] digit1,
  output logic       blank_tens,
  output logic       rolling,
  output logic       result_valid
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SETTLE, S_DONE} state_t;

  state_t     r_state;
  logic [3:0] r_d10, r_d1;
  logic [2:0] r_die;
  logic [4:0] r_step;
  logic [3:0] r_wait;
  logic       r_any_prev, r_block, r_rolling, r_valid;

  logic       w_any, w_edge, w_is100, w_step_due;
  logic [2:0] w_sel;
  logic [7:0] w_load, w_top, w_dec;

  function automatic logic [7:0] top_of(input logic [2:0] d);
    case (d)
      3'd0:    top_of = 8'h04;
      3'd1:    top_of = 8'h06;
      3'd2:    top_of = 8'h08;
      3'd3:    top_of = 8'h10;
      3'd4:    top_of = 8'h12;
      3'd5:    top_of = 8'h20;
      default: top_of = 8'h00;
    endcase
  endfunction

  assign w_any  = |btn;
  // r_block suppresses an edge for buttons that were already down at reset
  assign w_edge = w_any & ~r_any_prev & ~r_block;

  always_comb begin
    w_sel = 3'd0;
    for (int i = 6; i >= 0; i--)
      if (btn[i]) w_sel = 3'(i);
  end

  assign w_load  = top_of(w_sel);
  assign w_top   = top_of(r_die);
  assign w_is100 = (r_die == 3'd6);

  always_comb begin
    w_dec = {r_d10, r_d1 - 4'd1};
    if (!w_is100 && r_d10 == 4'd0 && r_d1 == 4'd1)
      w_dec = w_top;
    else if (r_d1 == 4'd0)
      w_dec = (r_d10 == 4'd0) ? 8'h99 : {r_d10 - 4'd1, 4'd9};
  end

  // Step s waits (s>>1)+1 ticks, so intervals run 1,1,2,2,3,3,...
  assign w_step_due = (r_wait == r_step[4:1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_d10      <= 4'd0;
      r_d1       <= 4'd1;
      r_die      <= 3'd1;
      r_step     <= 5'd0;
      r_wait     <= 4'd0;
      r_any_prev <= 1'b0;
      r_block    <= w_any;
      r_rolling  <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_any_prev <= w_any;
      if (!w_any) r_block <= 1'b0;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_edge) begin
          r_die     <= w_sel;
          {r_d10, r_d1} <= w_load;
          r_state   <= S_HOLD;
          r_rolling <= 1'b1;
        end
        S_HOLD: begin
          if (w_any) begin
            {r_d10, r_d1} <= w_dec;
          end else begin
            r_state <= S_SETTLE;
            r_step  <= 5'd0;
            r_wait  <= 4'd0;
          end
        end
        S_SETTLE: if (tick) begin
          if (w_step_due) begin
            {r_d10, r_d1} <= w_dec;
            r_step <= r_step + 5'd1;
            r_wait <= 4'd0;
            if (r_step == 5'(ANIM_STEPS - 1)) begin
              r_state   <= S_DONE;
              r_rolling <= 1'b0;
              r_valid   <= 1'b1;
            end
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign digit10      = r_d10;
  assign digit1       = r_d1;
  assign blank_tens   = (r_d10 == 4'd0) && !w_is100;
  assign rolling      = r_rolling;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_dice_roll_controller.sv
// Scoreboarded bench for dice_roll_controller: per-roll final values queued at
// press time and popped on result_valid; intermediate values checked inline.
module tb_dice_roll_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [6:0] btn = 7'd0;
  logic [3:0] digit10, digit1;
  logic       blank_tens, rolling, result_valid;

  int n_checks = 0;
  int n_err = 0;
  int sb_q[$];
  int sizes[7] = '{4, 6, 8, 10, 12, 20, 100};

  dice_roll_controller #(.ANIM_STEPS(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn(btn),
    .digit10(digit10), .digit1(digit1), .blank_tens(blank_tens),
    .rolling(rolling), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int dec(input int n, input int v);
    if (n == 100) return (v + 99) % 100;
    return (v == 1) ? n : v - 1;
  endfunction

  // Result scoreboard
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      int e;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: result_valid with value %0d%0d, none expected", digit10, digit1);
      end else begin
        e = sb_q.pop_front();
        if ({digit10, digit1} !== {4'(e / 10), 4'(e % 10)}) begin
          n_err++;
          $display("FAIL sb_result: got %0d%0d expected %0d", digit10, digit1, e);
        end
      end
    end
  end

  task automatic run_roll(input logic [6:0] b, input int hold, input logic [6:0] sb, input string nm);
    int idx, n, v, fin, x;
    logic last;
    idx = 0;
    for (int i = 6; i >= 0; i--) if (b[i]) idx = i;
    n = sizes[idx];
    v = (n == 100) ? 0 : n;
    x = hold - 1 + 8;
    if (n == 100) fin = (100 - (x % 100)) % 100;
    else fin = ((((n - 1 - x) % n) + n) % n) + 1;
    sb_q.push_back(fin);
    btn = b;
    for (int h = 0; h < hold; h++) begin
      tick = h[0];
      cyc(1);
      if (h > 0) v = dec(n, v);
      n_checks++;
      if ({digit10, digit1} !== {4'(v / 10), 4'(v % 10)} || rolling !== 1'b1 ||
          blank_tens !== ((v < 10) && (n != 100))) begin
        n_err++;
        $display("FAIL %s_hold%0d: got %0d%0d blank=%b roll=%b expected %0d", nm, h, digit10, digit1, blank_tens, rolling, v);
      end
    end
    tick = 1'b0;
    btn = 7'd0;
    cyc(1);
    n_checks++;
    if ({digit10, digit1} !== {4'(v / 10), 4'(v % 10)} || rolling !== 1'b1) begin
      n_err++;
      $display("FAIL %s_release: got %0d%0d roll=%b expected %0d roll=1", nm, digit10, digit1, rolling, v);
    end
    btn = sb;
    for (int s = 0; s < 8; s++) begin
      for (int t = 0; t <= s / 2; t++) begin
        last = (s == 7) && (t == s / 2);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        if (t == s / 2) v = dec(n, v);
        n_checks++;
        if ({digit10, digit1} !== {4'(v / 10), 4'(v % 10)} || result_valid !== last ||
            rolling !== !last || blank_tens !== ((v < 10) && (n != 100))) begin
          n_err++;
          $display("FAIL %s_settle s%0d t%0d: got %0d%0d rv=%b roll=%b blank=%b expected %0d rv=%b",
                   nm, s, t, digit10, digit1, result_valid, rolling, blank_tens, v, last);
        end
        if (!last) begin
          cyc(2);
          n_checks++;
          if (result_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_early_valid: result_valid=%b expected 0", nm, result_valid);
          end
        end
      end
    end
    cyc(1);
    n_checks++;
    if (result_valid !== 1'b0 || rolling !== 1'b0 || {digit10, digit1} !== {4'(fin / 10), 4'(fin % 10)}) begin
      n_err++;
      $display("FAIL %s_after_done: rv=%b roll=%b val=%0d%0d expected rv=0 roll=0 val=%0d", nm, result_valid, rolling, digit10, digit1, fin);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      n_checks++;
      if (digit10 !== 4'd0 || digit1 !== 4'd1 || rolling !== 1'b0 || result_valid !== 1'b0 || blank_tens !== 1'b1) begin
        n_err++;
        $display("FAIL reset_c%0d: got %0d%0d roll=%b rv=%b blank=%b expected 01 0 0 1", i, digit10, digit1, rolling, result_valid, blank_tens);
      end
      cyc(1);
    end
  endtask

  task automatic test_d6();           run_roll(7'b0000010, 5, 7'd0, "d6"); cyc(3); endtask
  task automatic test_d100();         run_roll(7'b1000000, 3, 7'd0, "d100"); cyc(3); endtask
  task automatic test_d100_zero();    run_roll(7'b1000000, 93, 7'd0, "d100z"); cyc(3); endtask
  task automatic test_simultaneous(); run_roll(7'b0101000, 4, 7'b0000001, "simul"); btn = 7'd0; cyc(3); endtask
  task automatic test_d4();           run_roll(7'b0000001, 2, 7'd0, "d4"); cyc(3); endtask

  task automatic test_reset_mid_settle();
    btn = 7'b0000010;
    cyc(3);
    btn = 7'd0;
    cyc(1);
    btn = 7'b0000010;
    repeat (2) begin tick = 1'b1; cyc(1); tick = 1'b0; cyc(2); end
    tick = 1'b1;
    rst = 1'b1;
    cyc(1);
    tick = 1'b0;
    rst = 1'b0;
    n_checks++;
    if ({digit10, digit1} !== 8'h01 || rolling !== 1'b0 || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_reset: got %0d%0d roll=%b rv=%b expected 01 0 0", digit10, digit1, rolling, result_valid);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n_checks++;
      if (rolling !== 1'b0 || {digit10, digit1} !== 8'h01) begin
        n_err++;
        $display("FAIL midrst_held%0d: roll=%b val=%0d%0d expected 0 01", i, rolling, digit10, digit1);
      end
    end
    btn = 7'd0;
    cyc(2);
    run_roll(7'b0000010, 2, 7'd0, "midrst_repress");
    cyc(3);
  endtask

  task automatic test_back_to_back();
    run_roll(7'b0010000, 6, 7'b0000010, "b2b");
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      n_checks++;
      if (rolling !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_held%0d: rolling=%b expected 0", i, rolling);
      end
    end
    btn = 7'd0;
    cyc(1);
    run_roll(7'b0100000, 7, 7'd0, "b2b_d20");
    cyc(3);
  endtask

  initial begin
    test_reset();
    test_d6();
    test_d100();
    test_d100_zero();
    test_simultaneous();
    test_reset_mid_settle();
    test_d4();
    test_back_to_back();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d results never arrived, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
